// File: rtl/attn_out_collector.sv
// Collects attention-top output beats into a 4x32 entry frame buffer
// and drains them row-major through a valid/ready port.
module attn_out_collector (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [1:0]   in_row,
  input  logic [4:0]   in_group,
  input  logic [127:0] in_data,
  input  logic         in_done,
  input  logic         clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_row,
  output logic [4:0]   out_group,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         out_frame_last,
  output logic         busy,
  output logic         drain_done,
  output logic         err_dup,
  output logic         err_incomplete,
  output logic         err_overrun
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   fill_q, fill_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [6:0]     idx_q, idx_d;
  logic           done_q, done_d;
  logic           dup_q, dup_d;
  logic           inc_q, inc_d;
  logic           ovr_q, ovr_d;
  logic           wr_en;
  logic [6:0]     in_idx;
  logic [127:0]   mem_q [128];

  assign in_idx = {in_row, in_group};

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    dup_d   = dup_q & ~clr;
    inc_d   = inc_q & ~clr;
    ovr_d   = ovr_q & ~clr;
    wr_en   = 1'b0;
    unique case (state_q)
      S_COLLECT: begin
        if (in_valid) begin
          if (fill_q[in_idx]) begin
            dup_d = 1'b1;
          end else begin
            wr_en          = 1'b1;
            fill_d[in_idx] = 1'b1;
            cnt_d          = cnt_q + 8'd1;
          end
        end
        // completeness includes a beat landing in the same cycle
        if (in_done) begin
          state_d = S_DRAIN;
          idx_d   = 7'd0;
          if (cnt_d < 8'd128) inc_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (in_valid || in_done) ovr_d = 1'b1;
        if (out_ready) begin
          if (idx_q == 7'd127) begin
            fill_d  = '0;
            cnt_d   = 8'd0;
            idx_d   = 7'd0;
            state_d = S_COLLECT;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_COLLECT;
      fill_q  <= '0;
      cnt_q   <= 8'd0;
      idx_q   <= 7'd0;
      done_q  <= 1'b0;
      dup_q   <= 1'b0;
      inc_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      dup_q   <= dup_d;
      inc_q   <= inc_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[in_idx] <= in_data;
  end

  assign out_valid      = (state_q == S_DRAIN);
  assign out_row        = idx_q[6:5];
  assign out_group      = idx_q[4:0];
  assign out_data       = fill_q[idx_q] ? mem_q[idx_q] : 128'h0;
  assign out_last       = out_valid && (idx_q[4:0] == 5'd31);
  assign out_frame_last = out_valid && (idx_q == 7'd127);
  assign busy           = out_valid || (cnt_q != 8'd0);
  assign drain_done     = done_q;
  assign err_dup        = dup_q;
  assign err_incomplete = inc_q;
  assign err_overrun    = ovr_q;

endmodule

// File: tb/tb_attn_out_collector.sv
// Randomized bench for attn_out_collector against a frame-level
// scoreboard model of the collect/drain behaviour.
module tb_attn_out_collector;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [1:0]   in_row = '0;
  logic [4:0]   in_group = '0;
  logic [127:0] in_data = '0;
  logic         in_done = 1'b0;
  logic         clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [1:0]   out_row;
  logic [4:0]   out_group;
  logic [127:0] out_data;
  logic         out_last;
  logic         out_frame_last;
  logic         busy;
  logic         drain_done;
  logic         err_dup;
  logic         err_incomplete;
  logic         err_overrun;

  attn_out_collector dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_row(in_row),
    .in_group(in_group), .in_data(in_data),
    .in_done(in_done), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_group(out_group),
    .out_data(out_data), .out_last(out_last),
    .out_frame_last(out_frame_last), .busy(busy),
    .drain_done(drain_done), .err_dup(err_dup),
    .err_incomplete(err_incomplete),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [127:0] mdata [128];
  bit           mfill [128];
  int           mcnt = 0;
  bit           mdup = 0, minc = 0, movr = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int i, input int seed);
    logic [31:0] w;
    w = 32'(i) ^ 32'(seed);
    return {4{w}};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mfill[i] = 0;
    mcnt = 0;
  endtask

  task automatic beat(input int i, input logic [127:0] d,
                      input bit done);
    in_valid = 1'b1;
    in_row   = i[6:5];
    in_group = i[4:0];
    in_data  = d;
    in_done  = done;
    if (mfill[i]) mdup = 1;
    else begin
      mfill[i] = 1;
      mdata[i] = d;
      mcnt++;
    end
    if (done && mcnt < 128) minc = 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_done  = 1'b0;
  endtask

  task automatic fill(input int skip, input bit with_done,
                      input int seed);
    int q[$];
    int t, r;
    for (int i = 0; i < 128; i++) if (i != skip) q.push_back(i);
    for (int k = q.size() - 1; k > 0; k--) begin
      r = $urandom_range(k, 0);
      t = q[k]; q[k] = q[r]; q[r] = t;
    end
    for (int k = 0; k < q.size(); k++)
      beat(q[k], pat(q[k], seed), with_done && k == q.size() - 1);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_dup"}, err_dup, mdup);
    check({tag, "_inc"}, err_incomplete, minc);
    check({tag, "_ovr"}, err_overrun, movr);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    mdup = 0; minc = 0; movr = 0;
    @(negedge clk);
    check_flags("clr");
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit bp, input int ovr_at,
                       input int abort_at, input bit done_sent);
    int j;
    int cyc;
    logic [127:0] exp;
    if (!done_sent) begin
      in_done = 1'b1;
      if (mcnt < 128) minc = 1;
      @(posedge clk); #1;
      in_done = 1'b0;
    end
    j = 0;
    cyc = 0;
    while (j < 128) begin
      if (cyc > 4000) begin
        check("drain_timeout", 1, 0);
        break;
      end
      if (j == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        mdup = 0; minc = 0; movr = 0;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", drain_done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_done2", drain_done, 0);
        check_flags("abort");
        @(posedge clk); #1;
        return;
      end
      out_ready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
      in_valid  = (cyc == ovr_at);
      if (cyc == ovr_at) movr = 1;
      @(negedge clk);
      exp = mfill[j] ? mdata[j] : 128'h0;
      check("valid", out_valid, 1);
      check("row", out_row, j[6:5]);
      check("group", out_group, j[4:0]);
      check("data", out_data, exp);
      check("last", out_last, (j % 32) == 31);
      check("flast", out_frame_last, j == 127);
      check("done_early", drain_done, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_ready) j++;
      cyc++;
    end
    if (!bp) check("latency", cyc, 128);
    model_reset();
    @(negedge clk);
    check("drain_done", drain_done, 1);
    check("post_valid", out_valid, 0);
    check("post_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_pulse", drain_done, 0);
    check_flags("drain");
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", drain_done, 0);
    check("rst_last", out_last, 0);
    check("rst_flast", out_frame_last, 0);
    check_flags("rst");
    @(posedge clk); #1;

    // full frame, ready tied high
    fill(-1, 0, 32'h0);
    @(negedge clk);
    check("fill_busy", busy, 1);
    check("fill_valid", out_valid, 0);
    @(posedge clk); #1;
    drain(0, -1, -1, 0);

    // backpressure
    fill(-1, 0, $urandom);
    drain(1, -1, -1, 0);

    // duplicate on index 37
    beat(37, 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004, 0);
    fill(-1, 0, $urandom);
    @(negedge clk);
    check("dup_flag", err_dup, mdup);
    @(posedge clk); #1;
    drain(1, -1, -1, 0);
    do_clr();

    // incomplete frame, index 90 missing
    fill(90, 0, $urandom);
    drain(0, -1, -1, 0);
    do_clr();

    // last beat with in_done, overrun mid-drain
    fill(-1, 1, $urandom);
    drain(0, 10, -1, 1);
    do_clr();

    // clr racing a new dup event keeps the flag
    beat(3, pat(3, 7), 0);
    clr = 1'b1;
    beat(3, pat(3, 8), 0);
    clr = 1'b0;
    mdup = 1;
    @(negedge clk);
    check("clr_race", err_dup, mdup);
    @(posedge clk); #1;
    do_clr();
    fill(-1, 0, $urandom);
    mdup = 1;
    drain(1, -1, -1, 0);
    do_clr();

    // reset during drain, then a clean frame
    fill(-1, 0, $urandom);
    drain(0, -1, 60, 0);
    fill(-1, 0, $urandom);
    drain(0, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/attn_out_collector.md
ATTN_OUT_COLLECTOR -- requirements
Module: attn_out_collector

Interface
REQ-001 The block SHALL use the following ports (clock and reset first); entry index is (row*32 + group).
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  attention-top output beat valid (out_valid of attn_top_4x4_128_mha4)
- in_row  in  2  beat row, 0..3
- in_group  in  5  beat group, 0..31; head = group[4:3]
- in_data  in  128  four FP32 lanes, lane0 = [31:0]
- in_done  in  1  one-cycle end-of-computation pulse from the attention top
- clr  in  1  synchronous clear of sticky error flags
- out_valid  out  1  drain beat valid
- out_ready  in  1  downstream accept
- out_row  out  2  row of current drain beat
- out_group  out  5  group of current drain beat
- out_data  out  128  stored beat; 128'h0 if entry never written
- out_last  out  1  high on group==31 beat (end of row)
- out_frame_last  out  1  high on entry 127 beat
- busy  out  1  high in DRAIN, or in COLLECT with fill count != 0
- drain_done  out  1  one-cycle pulse after final drain handshake
- err_dup  out  1  sticky: entry written twice in one frame
- err_incomplete  out  1  sticky: in_done seen with fill count < 128
- err_overrun  out  1  sticky: in_valid or in_done during DRAIN

Function
REQ-002 The block SHALL hold a 128 x 128-bit buffer, a 128-bit fill bitmap and an 8-bit fill count (0..128).
REQ-003 The FSM SHALL have exactly two states, COLLECT and DRAIN; reset state COLLECT.
REQ-004 In COLLECT, in_valid on an unfilled entry SHALL write in_data, set its fill bit and increment fill count in that cycle.
REQ-005 In COLLECT, in_valid on a filled entry SHALL be dropped (data unchanged, count unchanged) and set err_dup.
REQ-006 In COLLECT, in_done SHALL move to DRAIN next cycle; completeness is evaluated including an in_valid beat in the same cycle.
REQ-007 If the fill count after that same-cycle update is below 128, err_incomplete SHALL be set; the drain still proceeds.
REQ-008 In DRAIN, in_valid beats SHALL be dropped and set err_overrun; in_done SHALL also set err_overrun and be otherwise ignored.
REQ-009 On DRAIN entry the drain index SHALL be 0 and out_valid SHALL be high from the first DRAIN cycle.
REQ-010 Drain order SHALL be row-major, index 0..127; out_row = index[6:5], out_group = index[4:0].
REQ-011 out_data SHALL be the buffer word at the drain index when its fill bit is set, else 128'h0.
REQ-012 out_valid, out_row, out_group, out_data, out_last, out_frame_last SHALL remain stable while out_valid && !out_ready.
REQ-013 The index SHALL advance by one only on out_valid && out_ready.
REQ-014 On the handshake at index 127 the block SHALL, in that cycle, clear the bitmap and fill count and return to COLLECT next cycle, with drain_done high for exactly that next cycle and out_valid low.
REQ-015 Latency: in_done at edge N -> first out_valid at N+1; with out_ready tied high, 128 beats at N+1..N+128, drain_done at N+129.
REQ-016 Sticky errors SHALL be cleared only by clr or rst; clr in the same cycle as a new error event SHALL leave the flag set.
REQ-017 out_valid SHALL be low in COLLECT.

Reset
REQ-018 rst SHALL force COLLECT, clear bitmap, fill count and drain index, and drive out_valid, out_last, out_frame_last, busy, drain_done, err_dup, err_incomplete, err_overrun to 0; buffer contents need not be reset.
REQ-019 rst asserted mid-DRAIN SHALL abort the drain with no drain_done pulse; the next frame starts empty.

Verification
REQ-020 Full frame: 128 beats with in_data = {4{index}} in random order, in_done, out_ready=1 -> 128 beats index 0..127 in order, out_last on every 32nd, out_frame_last on the 128th, drain_done at N+129, no errors.
REQ-021 Backpressure: random out_ready (50%) -> identical beat sequence, outputs stable during stalls, no beat lost or repeated.
REQ-022 Duplicate: entry (row 1, group 5) written with A then B -> err_dup=1, drained index 37 carries A.
REQ-023 Incomplete: 127 beats, index 90 missing, in_done -> err_incomplete=1, index 90 drains as 128'h0, others correct.
REQ-024 Simultaneous/overrun: 128th beat in the same cycle as in_done -> no err_incomplete; an in_valid during DRAIN -> err_overrun=1, drain unaffected; clr then clears all flags.
REQ-025 Reset mid-drain at index 60 -> out_valid=0, busy=0 next cycle, no drain_done; a following full frame drains correctly.
